// File: rtl/gp4_vector_writer.sv
`default_nettype none
// ============================================================================
// Module      : gp4_vector_writer
// Description : Enumerates every {gin,pin,cin} gp4 input vector and streams the
//               golden {gin,pin,cin,gout,pout,cout} record over valid/ready.
// Revision    : 1.0  initial release
// ============================================================================
module gp4_vector_writer #(
   parameter int NUM_VECTORS = 512,
   parameter int IDX_W       = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [13:0]      o_record,
   output logic [IDX_W-1:0] o_index,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic [13:0]      record_q, record_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             done_q, done_d;

   // Index bits map as gin=idx[8:5], pin=idx[4:1], cin=idx[0]; narrower
   // indices are zero-extended so small runs cover the low cin/pin space.
   function automatic logic [13:0] f_record(input logic [IDX_W-1:0] idx);
      logic [8:0] v;
      logic [3:0] g;
      logic [3:0] p;
      logic       c0;
      logic [2:0] co;
      logic       go;
      logic       po;
      v     = 9'(idx);
      g     = v[8:5];
      p     = v[4:1];
      c0    = v[0];
      co[0] = g[0] | (p[0] & c0);
      co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      go    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      po    = &p;
      return {g, p, c0, go, po, co};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         valid_q  <= 1'b0;
         record_q <= '0;
         index_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         record_q <= record_d;
         index_q  <= index_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      record_d = record_q;
      index_d  = index_q;
      done_d   = done_q;

      if (i_abort) begin
         // Abort wins over start and over any handshake in the same cycle.
         state_d = S_IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  state_d  = S_SEND;
                  valid_d  = 1'b1;
                  done_d   = 1'b0;
                  index_d  = '0;
                  record_d = f_record('0);
               end
            end
            S_SEND: begin
               if (valid_q && i_ready) begin
                  if (index_q == LAST_IDX) begin
                     state_d = S_DONE;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     index_d  = index_q + 1'b1;
                     record_d = f_record(index_q + 1'b1);
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign o_valid  = valid_q;
   assign o_record = record_q;
   assign o_index  = index_q;
   assign o_busy   = (state_q == S_SEND);
   assign o_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gp4_vector_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp4_vector_writer
// Description : Directed, table-driven bench for gp4_vector_writer (512 and 16
//               vector configurations).
// Revision    : 1.0  initial release
// ============================================================================
module tb_gp4_vector_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        a_start, a_abort, a_ready, a_valid, a_busy, a_done;
   logic [13:0] a_rec;
   logic [8:0]  a_idx;

   logic        b_start, b_abort, b_ready, b_valid, b_busy, b_done;
   logic [13:0] b_rec;
   logic [3:0]  b_idx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          idx;
      logic [13:0] rec;
   } vec_t;

   vec_t        vt[7];
   logic [13:0] acc[512];

   int          exp_i, n, cyc;
   logic        stalled;
   logic [13:0] prev_rec;
   logic [8:0]  prev_idx;

   always #5 clk = ~clk;

   gp4_vector_writer #(.NUM_VECTORS(512), .IDX_W(9)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_abort(a_abort),
      .o_valid(a_valid), .i_ready(a_ready), .o_record(a_rec), .o_index(a_idx),
      .o_busy(a_busy), .o_done(a_done)
   );

   gp4_vector_writer #(.NUM_VECTORS(16), .IDX_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
      .o_valid(b_valid), .i_ready(b_ready), .o_record(b_rec), .o_index(b_idx),
      .o_busy(b_busy), .o_done(b_done)
   );

   // Ripple formulation of the generate/propagate chain.
   function automatic logic [13:0] model(input int idx);
      logic [8:0] x;
      logic [3:0] g, p;
      logic       c, go;
      logic [2:0] co;
      x = idx[8:0];
      g = x[8:5];
      p = x[4:1];
      c = x[0];
      for (int i = 0; i < 3; i++) begin
         c     = g[i] | (p[i] & c);
         co[i] = c;
      end
      go = g[0];
      for (int i = 1; i < 4; i++) go = g[i] | (p[i] & go);
      return {g, p, x[0], go, &p, co};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_start = 0; a_abort = 0; a_ready = 0;
      b_start = 0; b_abort = 0; b_ready = 0;

      vt[0] = '{0,   14'b0000_0000_0_0_0_000};
      vt[1] = '{31,  14'b0000_1111_1_0_1_111};
      vt[2] = '{32,  14'b0001_0000_0_0_0_001};
      vt[3] = '{511, 14'b1111_1111_1_1_1_111};
      vt[4] = '{5,   14'b0000_0010_1_0_0_000};
      vt[5] = '{271, 14'b1000_0111_1_1_0_111};
      vt[6] = '{88,  14'b0010_1100_0_1_0_110};

      repeat (3) step();
      chk("rst_valid", a_valid, 0);
      chk("rst_record", a_rec, 0);
      chk("rst_index", a_idx, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      rst_n = 1;
      step();

      // Full run, consumer always ready: one record per cycle.
      a_ready = 1; a_start = 1;
      step();
      a_start = 0;
      chk("start_valid", a_valid, 1);
      chk("start_index", a_idx, 0);
      chk("start_record", a_rec, 0);
      chk("start_busy", a_busy, 1);
      chk("start_done", a_done, 0);
      exp_i = 0; n = 0;
      while (a_valid && n < 600) begin
         chk("seq_index", a_idx, exp_i);
         chk("seq_record", a_rec, model(exp_i));
         acc[a_idx] = a_rec;
         exp_i++; n++;
         step();
      end
      chk("run1_count", exp_i, 512);
      chk("run1_done", a_done, 1);
      chk("run1_valid", a_valid, 0);
      chk("run1_busy", a_busy, 0);
      for (int i = 0; i < 7; i++)
         chk($sformatf("table_idx%0d", vt[i].idx), acc[vt[i].idx], vt[i].rec);

      // Random back-pressure with a start pulse while sending.
      a_ready = 0; a_start = 1;
      step();
      a_start = 0;
      chk("bp_first_valid", a_valid, 1);
      chk("bp_done_cleared", a_done, 0);
      exp_i = 0; cyc = 0; stalled = 0;
      while (!a_done && cyc < 5000) begin
         if (stalled) begin
            chk("stall_record", a_rec, prev_rec);
            chk("stall_index", a_idx, prev_idx);
         end
         a_start = (cyc == 40);
         a_ready = 1'($urandom_range(0, 1));
         if (a_valid && a_ready) begin
            chk("bp_index", a_idx, exp_i);
            chk("bp_record", a_rec, model(exp_i));
            exp_i++;
         end
         stalled  = a_valid && !a_ready;
         prev_rec = a_rec;
         prev_idx = a_idx;
         step();
         cyc++;
      end
      a_start = 0;
      chk("bp_count", exp_i, 512);
      chk("bp_done", a_done, 1);

      // Abort at index 100, then restart.
      a_ready = 1; a_start = 1;
      step();
      a_start = 0;
      n = 0;
      while (a_idx != 9'd100 && n < 200) begin step(); n++; end
      chk("abort_at_idx", a_idx, 100);
      a_abort = 1;
      step();
      a_abort = 0;
      chk("abort_valid", a_valid, 0);
      chk("abort_done", a_done, 0);
      chk("abort_busy", a_busy, 0);
      step();
      chk("abort_idle_valid", a_valid, 0);
      a_start = 1;
      step();
      a_start = 0;
      chk("restart_valid", a_valid, 1);
      chk("restart_index", a_idx, 0);
      chk("restart_record", a_rec, model(0));

      // Asynchronous reset mid-cycle at index 200.
      n = 0;
      while (a_idx != 9'd200 && n < 300) begin step(); n++; end
      chk("rst_at_idx", a_idx, 200);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", a_valid, 0);
      chk("arst_record", a_rec, 0);
      chk("arst_index", a_idx, 0);
      chk("arst_busy", a_busy, 0);
      chk("arst_done", a_done, 0);
      step();
      rst_n = 1;
      step();
      a_ready = 0; a_start = 1;
      step();
      chk("post_rst_valid", a_valid, 1);
      chk("post_rst_index", a_idx, 0);
      step();
      a_start = 0;
      chk("start_in_send_index", a_idx, 0);
      chk("start_in_send_busy", a_busy, 1);
      a_ready = 1;
      step();
      chk("post_rst_next_index", a_idx, 1);
      chk("post_rst_next_record", a_rec, model(1));
      a_abort = 1;
      step();
      a_abort = 0; a_ready = 0;

      // 16-vector configuration, then a rerun from DONE.
      b_ready = 1; b_start = 1;
      step();
      b_start = 0;
      exp_i = 0; n = 0;
      while (b_valid && n < 40) begin
         chk("n16_index", b_idx, exp_i);
         chk("n16_record", b_rec, model(exp_i));
         exp_i++; n++;
         step();
      end
      chk("n16_count", exp_i, 16);
      chk("n16_done", b_done, 1);
      chk("n16_valid", b_valid, 0);
      b_start = 1;
      step();
      b_start = 0;
      chk("n16_rerun_valid", b_valid, 1);
      chk("n16_rerun_index", b_idx, 0);
      chk("n16_rerun_done", b_done, 0);
      exp_i = 0; cyc = 0;
      while (!b_done && cyc < 200) begin
         b_ready = 1'($urandom_range(0, 1));
         if (b_valid && b_ready) begin
            chk("n16_rerun_record", b_rec, model(exp_i));
            exp_i++;
         end
         step();
         cyc++;
      end
      chk("n16_rerun_count", exp_i, 16);
      chk("n16_rerun_final_done", b_done, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
